serial_add_ctrl: RTL and testbench

Bit-serial adder controller. It time-shares a single full-adder cell (sum = a^b^c, carry = ab+bc+ca) to add two WIDTH-bit operands one bit per clock, LSB first, with a registered carry between bits. It sits between an operand producer and a result consumer, with a valid/ready handshake on each side. It processes one operation at a time; there is no overlap between operations.

---
 rtl/serial_add_ctrl.sv | 103 ++++++++++
 tb/tb_serial_add_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder cell is reused for WIDTH cycles, LSB first,
// with valid/ready handshakes on the operand and result sides.
module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] r_sr;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             fa_s;
   logic             fa_c;
   logic             last;

   // The shared full-adder cell
   assign fa_s = a_sr[0] ^ b_sr[0] ^ carry;
   assign fa_c = (a_sr[0] & b_sr[0]) | (b_sr[0] & carry) | (carry & a_sr[0]);
   assign last = (cnt == LAST);

   // Handshake outputs depend on state only, no input-to-output paths
   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid)  state_nxt = RUN;
         RUN:     if (last)      state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default:                state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sr  <= '0;
         b_sr  <= '0;
         r_sr  <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_sr  <= a;
                  b_sr  <= b;
                  carry <= cin;
                  cnt   <= '0;
               end
            end
            RUN: begin
               a_sr  <= a_sr >> 1;
               b_sr  <= b_sr >> 1;
               r_sr  <= {fa_s, r_sr[WIDTH-1:1]};
               carry <= fa_c;
               // Counter holds on the final bit so it never wraps mid-operation
               if (last) begin
                  sum  <= {fa_s, r_sr[WIDTH-1:1]};
                  cout <= fa_c;
                  ovf  <= fa_c ^ carry;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: WIDTH=8 directed/random vectors plus exhaustive
// WIDTH=2 and WIDTH=3 runs, all checked against an arithmetic reference.
module tb_serial_add_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] iv = '0;
   logic [2:0] ordy = '0;
   logic [2:0] ci = '0;
   wire  [2:0] ir;
   wire  [2:0] ov;
   wire  [2:0] co;
   wire  [2:0] of;
   logic [7:0] a8 = '0, b8 = '0;
   logic [1:0] a2 = '0, b2 = '0;
   logic [2:0] a3 = '0, b3 = '0;
   wire  [7:0] s8;
   wire  [1:0] s2;
   wire  [2:0] s3;

   int nchk = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   serial_add_ctrl #(.WIDTH(8)) u8 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .a(a8), .b(b8),
      .cin(ci[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .sum(s8), .cout(co[0]), .ovf(of[0]));
   serial_add_ctrl #(.WIDTH(2)) u2 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .a(a2), .b(b2),
      .cin(ci[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .sum(s2), .cout(co[1]), .ovf(of[1]));
   serial_add_ctrl #(.WIDTH(3)) u3 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .a(a3), .b(b3),
      .cin(ci[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .sum(s3), .cout(co[2]), .ovf(of[2]));

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic [7:0] sum;
      logic       cout;
      logic       ovf;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Result packed as {ovf, cout, sum[31:0]}
   function automatic logic [33:0] ref_add(input int w, input longint av, input longint bv,
                                           input longint c);
      longint t, sa, sb, st, m;
      logic [33:0] r;
      m  = longint'(1) << w;
      t  = av + bv + c;
      sa = (av >= m / 2) ? av - m : av;
      sb = (bv >= m / 2) ? bv - m : bv;
      st = sa + sb + c;
      r[31:0] = 32'(t % m);
      r[32]   = ((t / m) != 0);
      r[33]   = (st > m / 2 - 1) || (st < -(m / 2));
      return r;
   endfunction

   function automatic logic [33:0] get_res(input int k);
      case (k)
         0:       return {of[0], co[0], 24'b0, s8};
         1:       return {of[1], co[1], 30'b0, s2};
         default: return {of[2], co[2], 29'b0, s3};
      endcase
   endfunction

   task automatic set_ops(input int k, input logic [31:0] av, input logic [31:0] bv,
                          input logic c);
      case (k)
         0:       begin a8 = av[7:0]; b8 = bv[7:0]; end
         1:       begin a2 = av[1:0]; b2 = bv[1:0]; end
         default: begin a3 = av[2:0]; b3 = bv[2:0]; end
      endcase
      ci[k] = c;
   endtask

   // Wait (bounded) for out_valid, optionally toggling out_ready while in RUN
   task automatic wait_done(input int k, input int w, input bit tog, input string name);
      int lat = 0;
      while (!ov[k] && lat < 200) begin
         if (tog) ordy[k] = 1'($urandom_range(0, 1));
         @(negedge clk);
         lat++;
      end
      ordy[k] = 1'b0;
      chk({name, " latency"}, 64'(lat), 64'(w));
   endtask

   task automatic do_op(input int k, input int w, input logic [31:0] av, input logic [31:0] bv,
                        input logic c, input logic [33:0] exp, input int stall, input bit tog,
                        input string name);
      @(negedge clk);
      set_ops(k, av, bv, c);
      iv[k] = 1'b1;
      chk({name, " in_ready idle"}, 64'(ir[k]), 64'd1);
      @(negedge clk);
      iv[k] = 1'b0;
      chk({name, " in_ready run"}, 64'(ir[k]), 64'd0);
      wait_done(k, w, tog, name);
      chk({name, " result"}, 64'(get_res(k)), 64'(exp));
      repeat (stall) begin
         @(negedge clk);
         chk({name, " stall"}, 64'({ov[k], get_res(k)}), 64'({1'b1, exp}));
      end
      ordy[k] = 1'b1;
      @(negedge clk);
      ordy[k] = 1'b0;
      chk({name, " handshake"}, 64'({ir[k], ov[k]}), 64'b10);
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t tbl[5];
      logic [33:0] e1, e2;
      logic [31:0] ra, rb;
      logic        rc;

      tbl[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
      tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
      tbl[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
      tbl[3] = '{8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 1'b1};
      tbl[4] = '{8'h35, 8'h4A, 1'b1, 8'h80, 1'b0, 1'b1};

      // Reset state
      repeat (3) @(negedge clk);
      chk("reset w8", 64'({ir[0], ov[0], get_res(0)}), 64'({2'b10, 34'b0}));
      chk("reset w2", 64'({ir[1], ov[1], get_res(1)}), 64'({2'b10, 34'b0}));
      chk("reset w3", 64'({ir[2], ov[2], get_res(2)}), 64'({2'b10, 34'b0}));
      rst_n = 1'b1;

      // Directed table
      for (int i = 0; i < 5; i++)
         do_op(0, 8, 32'(tbl[i].a), 32'(tbl[i].b), tbl[i].cin,
               {tbl[i].ovf, tbl[i].cout, 24'b0, tbl[i].sum}, i % 3, 1'b0, $sformatf("tbl%0d", i));

      // Backpressure with a new operand set held on the input side
      e1 = ref_add(8, 'hC3, 'h3C, 1);
      e2 = ref_add(8, 'h12, 'h34, 0);
      @(negedge clk);
      set_ops(0, 'hC3, 'h3C, 1'b1);
      iv[0] = 1'b1;
      @(negedge clk);
      set_ops(0, 'h12, 'h34, 1'b0);
      wait_done(0, 8, 1'b0, "bp1");
      chk("bp1 result", 64'(get_res(0)), 64'(e1));
      repeat (5) begin
         @(negedge clk);
         chk("bp hold", 64'({ir[0], ov[0], get_res(0)}), 64'({2'b01, e1}));
      end
      ordy[0] = 1'b1;
      @(negedge clk);
      ordy[0] = 1'b0;
      chk("bp release", 64'({ir[0], ov[0]}), 64'b10);
      @(negedge clk);
      iv[0] = 1'b0;
      chk("bp2 accepted", 64'(ir[0]), 64'd0);
      wait_done(0, 8, 1'b0, "bp2");
      chk("bp2 result", 64'(get_res(0)), 64'(e2));
      ordy[0] = 1'b1;
      @(negedge clk);
      ordy[0] = 1'b0;

      // Asynchronous reset during the third RUN cycle
      @(negedge clk);
      set_ops(0, 'h10, 'h20, 1'b0);
      iv[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      iv[0] = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 chk("reset mid-run", 64'({ir[0], ov[0], get_res(0)}), 64'({2'b10, 34'b0}));
      @(negedge clk);
      rst_n = 1'b1;
      do_op(0, 8, 'h35, 'h4A, 1'b1, {1'b1, 1'b0, 32'h80}, 1, 1'b0, "post-reset");

      // Random WIDTH=8 against the reference model
      for (int i = 0; i < 20; i++) begin
         ra = 32'($urandom_range(0, 255));
         rb = 32'($urandom_range(0, 255));
         rc = 1'($urandom_range(0, 1));
         do_op(0, 8, ra, rb, rc, ref_add(8, longint'(ra), longint'(rb), longint'(rc)),
               $urandom_range(0, 3), 1'b1, "rand8");
      end

      // Exhaustive WIDTH=2 and WIDTH=3
      for (int av = 0; av < 4; av++)
         for (int bv = 0; bv < 4; bv++)
            for (int c = 0; c < 2; c++)
               do_op(1, 2, 32'(av), 32'(bv), 1'(c), ref_add(2, av, bv, c),
                     $urandom_range(0, 2), 1'b1, $sformatf("w2 %0d+%0d+%0d", av, bv, c));
      for (int av = 0; av < 8; av++)
         for (int bv = 0; bv < 8; bv++)
            for (int c = 0; c < 2; c++)
               do_op(2, 3, 32'(av), 32'(bv), 1'(c), ref_add(3, av, bv, c),
                     $urandom_range(0, 2), 1'b1, $sformatf("w3 %0d+%0d+%0d", av, bv, c));

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
